// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot gate controller: sensor codes,
// FSM state encoding and the default lot capacity.
package parking_pkg;

    localparam logic [1:0] AB_CLR  = 2'b00;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;
    localparam logic [1:0] AB_A    = 2'b10;

    localparam int unsigned CAPACITY_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        IN1,
        IN2,
        IN3,
        OUT1,
        OUT2,
        OUT3,
        ERR
    } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debounce filter for the 2-bit sensor bus.
// changed pulses for one cycle after ab_f takes a new value.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic [1:0] ab_f,
    output logic       changed
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync1;
    logic [1:0]    ab_s;
    logic [1:0]    ab_p;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // ab_p holds last cycle's ab_s so any change of the candidate restarts the run at 1
    always_comb begin
        cnt_nxt = CW'(1);
        if (ab_s == ab_p) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            ab_s    <= '0;
            ab_p    <= '0;
            ab_f    <= '0;
            cnt     <= '0;
            changed <= 1'b0;
        end else begin
            sync1   <= ab;
            ab_s    <= sync1;
            ab_p    <= ab_s;
            changed <= 1'b0;
            if (ab_s == ab_f) begin
                cnt <= '0;
            end else if (cnt_nxt >= CW'(DEBOUNCE)) begin
                ab_f    <= ab_s;
                cnt     <= '0;
                changed <= 1'b1;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Two-sensor gate controller: debounced Gray-sequence tracking of entries and
// exits with a saturating occupancy count and sticky error flags.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = CAPACITY_DEF,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ab,
    input  logic             clr_err,
    output logic             entry,
    output logic             exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [1:0] ab_f;
    logic       changed;
    state_t     state;
    state_t     state_nxt;
    logic       ev_in;
    logic       ev_out;
    logic       jump;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .ab      (ab),
        .ab_f    (ab_f),
        .changed (changed)
    );

    assign full  = (count == CAP);
    assign empty = (count == '0);

    // ab_f only reports a change, so the default arm of each case is the two-bit jump
    always_comb begin
        state_nxt = state;
        ev_in     = 1'b0;
        ev_out    = 1'b0;
        if (changed) begin
            case (state)
                IDLE: begin
                    case (ab_f)
                        AB_B:    state_nxt = IN1;
                        AB_A:    state_nxt = OUT1;
                        AB_BOTH: state_nxt = ERR;
                        default: state_nxt = IDLE;
                    endcase
                end
                IN1: begin
                    case (ab_f)
                        AB_BOTH: state_nxt = IN2;
                        AB_CLR:  state_nxt = IDLE;
                        default: state_nxt = ERR;
                    endcase
                end
                IN2: begin
                    case (ab_f)
                        AB_A:    state_nxt = IN3;
                        AB_B:    state_nxt = IN1;
                        default: state_nxt = ERR;
                    endcase
                end
                IN3: begin
                    case (ab_f)
                        AB_CLR: begin
                            state_nxt = IDLE;
                            ev_in     = 1'b1;
                        end
                        AB_BOTH: state_nxt = IN2;
                        default: state_nxt = ERR;
                    endcase
                end
                OUT1: begin
                    case (ab_f)
                        AB_BOTH: state_nxt = OUT2;
                        AB_CLR:  state_nxt = IDLE;
                        default: state_nxt = ERR;
                    endcase
                end
                OUT2: begin
                    case (ab_f)
                        AB_B:    state_nxt = OUT3;
                        AB_A:    state_nxt = OUT1;
                        default: state_nxt = ERR;
                    endcase
                end
                OUT3: begin
                    case (ab_f)
                        AB_CLR: begin
                            state_nxt = IDLE;
                            ev_out    = 1'b1;
                        end
                        AB_BOTH: state_nxt = OUT2;
                        default: state_nxt = ERR;
                    endcase
                end
                ERR: begin
                    if (ab_f == AB_CLR) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        jump = (state_nxt == ERR) && (state != ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            entry <= 1'b0;
            exit  <= 1'b0;
        end else begin
            state <= state_nxt;
            entry <= ev_in;
            exit  <= ev_out;
        end
    end

    // Set terms are OR-ed after the clear so a coincident event wins over clr_err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            if (ev_in && !full) begin
                count <= count + 1'b1;
            end else if (ev_out && !empty) begin
                count <= count - 1'b1;
            end
            ovf     <= (ovf & ~clr_err) | (ev_in & full);
            udf     <= (udf & ~clr_err) | (ev_out & empty);
            seq_err <= (seq_err & ~clr_err) | jump;
        end
    end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Randomised scoreboard bench for parking_lot_ctrl against a Gray-position
// reference model of the gate sequence rules.
module tb_parking_lot_ctrl;
    import parking_pkg::*;

    localparam int unsigned CAP = 2;
    localparam int unsigned CW  = 2;
    localparam int unsigned DB  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ab;
    logic          clr_err;
    logic          entry;
    logic          exit;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
    logic          seq_err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit is_entry;
        int cnt;
        bit ovf;
        bit udf;
        bit serr;
    } ev_t;

    ev_t q[$];
    ev_t e;

    int         m_cnt;
    bit         m_ovf, m_udf, m_serr, m_err;
    int         m_dir, m_p;
    logic [1:0] m_cur;
    logic [1:0] gray_code[4];

    parking_lot_ctrl #(
        .CAPACITY (CAP),
        .CNT_W    (CW),
        .DEBOUNCE (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ab      (ab),
        .clr_err (clr_err),
        .entry   (entry),
        .exit    (exit),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gpos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_ovf  = 0;
        m_udf  = 0;
        m_serr = 0;
        m_err  = 0;
        m_dir  = 0;
        m_p    = 0;
        m_cur  = 2'b00;
        q.delete();
    endtask

    // Progress is counted in quarter-turns of the Gray cycle in the direction
    // chosen when leaving 00; four quarter-turns back to 00 completes a pass.
    task automatic model_step(input logic [1:0] v);
        int  d;
        ev_t x;
        if (v == m_cur) return;
        if (m_err) begin
            if (v == 2'b00) m_err = 0;
        end else if (m_cur == 2'b00) begin
            if (v == 2'b11) begin
                m_err  = 1;
                m_serr = 1;
            end else begin
                m_dir = (v == 2'b01) ? 1 : -1;
                m_p   = 1;
            end
        end else begin
            d = (gpos(v) - gpos(m_cur) + 4) % 4;
            if (d == 2) begin
                m_err  = 1;
                m_serr = 1;
            end else begin
                m_p += (d == 1) ? m_dir : -m_dir;
                if (v == 2'b00 && m_p == 4) begin
                    if (m_dir > 0) begin
                        if (m_cnt == CAP) m_ovf = 1;
                        else m_cnt++;
                    end else begin
                        if (m_cnt == 0) m_udf = 1;
                        else m_cnt--;
                    end
                    x.is_entry = (m_dir > 0);
                    x.cnt      = m_cnt;
                    x.ovf      = m_ovf;
                    x.udf      = m_udf;
                    x.serr     = m_serr;
                    q.push_back(x);
                end
            end
        end
        m_cur = v;
    endtask

    task automatic apply(input logic [1:0] v, input int hold);
        @(negedge clk);
        ab = v;
        model_step(v);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic glitch(input logic [1:0] v, input int n);
        @(negedge clk);
        ab = v;
        repeat (n) @(negedge clk);
        ab = m_cur;
        repeat (2) @(negedge clk);
    endtask

    task automatic seq4(input logic [7:0] vals);
        logic [7:0] t;
        t = vals;
        for (int i = 0; i < 4; i++) begin
            apply(t[7:6], 8);
            t = t << 2;
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (12) @(negedge clk);
        check({tag, "_count"}, count, m_cnt);
        check({tag, "_full"}, full, (m_cnt == CAP));
        check({tag, "_empty"}, empty, (m_cnt == 0));
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_udf"}, udf, m_udf);
        check({tag, "_seq_err"}, seq_err, m_serr);
        check({tag, "_pending"}, q.size(), 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf  = 0;
        m_udf  = 0;
        m_serr = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && (entry || exit)) begin
            if (entry && exit) check("pulse_exclusive", 1, 0);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: entry=%0b exit=%0b, none required at %0t",
                         entry, exit, $time);
            end else begin
                e = q.pop_front();
                check("pulse_kind_entry", entry, e.is_entry);
                check("pulse_kind_exit", exit, !e.is_entry);
                check("pulse_count", count, e.cnt);
                check("pulse_ovf", ovf, e.ovf);
                check("pulse_udf", udf, e.udf);
                check("pulse_seq_err", seq_err, e.serr);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] nv;
        gray_code[0] = 2'b00;
        gray_code[1] = 2'b01;
        gray_code[2] = 2'b11;
        gray_code[3] = 2'b10;
        reset   = 1'b1;
        ab      = 2'b00;
        clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_entry", entry, 0);
        check("rst_exit", exit, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        check("rst_seq_err", seq_err, 0);
        reset = 1'b0;

        apply(2'b00, 10);
        checkpoint("idle");
        seq4(8'b01_11_10_00);
        checkpoint("entry1");
        seq4(8'b10_11_01_00);
        checkpoint("exit1");
        glitch(2'b01, 3);
        checkpoint("glitch");
        seq4(8'b01_11_01_00);
        checkpoint("backoff");

        for (int i = 0; i < 3; i++) seq4(8'b01_11_10_00);
        checkpoint("overflow");
        for (int i = 0; i < 3; i++) seq4(8'b10_11_01_00);
        checkpoint("underflow");
        pulse_clr();
        checkpoint("clr");

        apply(2'b01, 8);
        apply(2'b10, 8);
        checkpoint("jump");
        apply(2'b00, 8);
        seq4(8'b01_11_10_00);
        checkpoint("after_err");

        apply(2'b01, 8);
        apply(2'b11, 10);
        @(negedge clk);
        reset = 1'b1;
        ab    = 2'b00;
        repeat (3) @(negedge clk);
        check("midrst_count", count, 0);
        check("midrst_entry", entry, 0);
        reset = 1'b0;
        model_reset();
        checkpoint("midrst");

        for (int w = 0; w < 60; w++) begin
            int steps;
            steps = $urandom_range(3, 8);
            for (int s = 0; s < steps; s++) begin
                if ($urandom_range(0, 5) == 0) begin
                    nv = m_cur ^ 2'($urandom_range(1, 3));
                    glitch(nv, $urandom_range(1, 3));
                end
                if ($urandom_range(0, 3) != 0) begin
                    nv = gray_code[(gpos(m_cur) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4];
                end else begin
                    nv = m_cur ^ 2'($urandom_range(1, 3));
                end
                apply(nv, $urandom_range(8, 11));
            end
            apply(2'b00, 8);
            checkpoint("rand");
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        checkpoint("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
